// File: rtl/proc_share_arbiter_if.sv
// Channel request/ack and shared-unit handshake bundle for proc_share_arbiter.
// master is the arbiter side; slave is the channel controllers plus the shared unit.
interface proc_share_arbiter_if;
  logic [1:0] Req;
  logic [1:0] Ack;
  logic       Sel;
  logic       Active;
  logic       UnitStart;
  logic       UnitBusy;
  logic       UnitEnd;
  logic       Timeout;
  logic       ErrFlag;

  modport master (
    input  Req, UnitBusy, UnitEnd,
    output Ack, Sel, Active, UnitStart, Timeout, ErrFlag
  );

  modport slave (
    output Req, UnitBusy, UnitEnd,
    input  Ack, Sel, Active, UnitStart, Timeout, ErrFlag
  );
endinterface

// File: rtl/proc_share_arbiter.sv
// Round-robin sharing of one Start/Busy/End processing unit between two channels,
// with single-pulse start, one-cycle ack to the owner and a watchdog abort.
module proc_share_arbiter #(
  parameter int TIMEOUT = 1024,
  parameter int CW      = 11
) (
  input logic                 Clock,
  input logic                 Reset,
  proc_share_arbiter_if.master bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT - 1);

  state_t        state_r;
  logic          last_r;
  logic          busy_d_r;
  logic [CW-1:0] count_r;
  logic [1:0]    ack_r;
  logic          sel_r;
  logic          active_r;
  logic          start_r;
  logic          timeout_r;
  logic          err_r;

  logic          grant_s;
  logic          done_s;
  logic          expire_s;

  function automatic logic [1:0] ack_vec(input logic ch);
    return ch ? 2'b10 : 2'b01;
  endfunction

  // Winner selection and completion/watchdog detection.
  always_comb begin
    grant_s  = sel_r;
    done_s   = 1'b0;
    expire_s = 1'b0;
    if (bus.Req == 2'b11) begin
      grant_s = ~last_r;
    end else begin
      grant_s = bus.Req[1];
    end
    // A sub-cycle End may be missed by the edge, so a Busy fall also counts.
    done_s   = bus.UnitEnd | (busy_d_r & ~bus.UnitBusy);
    expire_s = (count_r == LIMIT);
  end

  // Arbitration state machine with all outputs registered.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_r   <= IDLE;
      last_r    <= 1'b1;
      busy_d_r  <= 1'b0;
      count_r   <= {CW{1'b0}};
      ack_r     <= 2'b00;
      sel_r     <= 1'b0;
      active_r  <= 1'b0;
      start_r   <= 1'b0;
      timeout_r <= 1'b0;
      err_r     <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          ack_r     <= 2'b00;
          timeout_r <= 1'b0;
          start_r   <= 1'b0;
          if (bus.Req != 2'b00) begin
            sel_r    <= grant_s;
            active_r <= 1'b1;
            start_r  <= 1'b1;
            state_r  <= START;
          end else begin
            state_r  <= IDLE;
          end
        end
        START: begin
          start_r  <= 1'b0;
          count_r  <= {CW{1'b0}};
          busy_d_r <= 1'b0;
          state_r  <= WAIT;
        end
        WAIT: begin
          busy_d_r <= bus.UnitBusy;
          if (count_r != {CW{1'b1}}) begin
            count_r <= count_r + CW'(1);
          end
          if (done_s) begin
            ack_r   <= ack_vec(sel_r);
            state_r <= DONE;
          end else if (expire_s) begin
            // Ack still goes out so the requester cannot deadlock on a hung unit.
            ack_r     <= ack_vec(sel_r);
            timeout_r <= 1'b1;
            err_r     <= 1'b1;
            state_r   <= DONE;
          end else begin
            state_r <= WAIT;
          end
        end
        DONE: begin
          ack_r     <= 2'b00;
          timeout_r <= 1'b0;
          last_r    <= sel_r;
          active_r  <= 1'b0;
          state_r   <= IDLE;
        end
        default: begin
          ack_r     <= 2'b00;
          timeout_r <= 1'b0;
          start_r   <= 1'b0;
          active_r  <= 1'b0;
          state_r   <= IDLE;
        end
      endcase
    end
  end

  assign bus.Ack       = ack_r;
  assign bus.Sel       = sel_r;
  assign bus.Active    = active_r;
  assign bus.UnitStart = start_r;
  assign bus.Timeout   = timeout_r;
  assign bus.ErrFlag   = err_r;

endmodule

// File: tb/tb_proc_share_arbiter.sv
// Bench for proc_share_arbiter: directed scenarios then randomized transactions,
// each transaction's outcome predicted from its unit schedule and round-robin rules.
module tb_proc_share_arbiter;
  localparam int TIMEOUT = 16;

  logic Clock = 1'b0;
  logic Reset;
  int   checks = 0;
  int   errors = 0;

  logic last_owner;
  logic err_model;
  logic sel_model;

  always #5 Clock = ~Clock;

  proc_share_arbiter_if bus ();

  proc_share_arbiter #(.TIMEOUT(TIMEOUT), .CW(11)) dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus.master)
  );

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic [1:0] ack, input logic sel,
                         input logic act, input logic st, input logic to);
    logic [6:0] o;
    logic [6:0] e;
    o = {bus.Ack, bus.Sel, bus.Active, bus.UnitStart, bus.Timeout, bus.ErrFlag};
    e = {ack, sel, act, st, to, err_model};
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b (Ack,Sel,Active,UnitStart,Timeout,ErrFlag)",
             tag, o, e);
    end
  endtask

  // Req must be 00 here; the unit pins toggle at random and must be ignored.
  task automatic idle_quiet(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      bus.UnitBusy = 1'($urandom_range(0, 1));
      bus.UnitEnd  = 1'($urandom_range(0, 1));
      tick();
      chk_out(tag, 2'b00, sel_model, 1'b0, 1'b0, 1'b0);
    end
    bus.UnitBusy = 1'b0;
    bus.UnitEnd  = 1'b0;
  endtask

  // Caller has driven Req (nonzero) just after an edge with the arbiter idle.
  // Unit schedule in WAIT cycles 1..: Busy high for cycles a..a+len-1 (forever if hung),
  // a full-cycle End in cycle e (0 = none), optional sub-cycle End glitch at the fall.
  task automatic run_txn(input string tag, input int a, input int len, input int e,
                         input bit hung, input bit glitch, input bit add_other);
    logic winner;
    int   completion;
    int   done_j;
    bit   to_exp;
    winner     = (bus.Req == 2'b11) ? ~last_owner : bus.Req[1];
    completion = 1 << 30;
    if (e > 0) completion = e;
    if (len > 0 && !hung && (a + len) < completion) completion = a + len;
    to_exp = (completion > TIMEOUT);
    done_j = to_exp ? TIMEOUT : completion;

    tick();
    sel_model = winner;
    chk_out({tag, "_start"}, 2'b00, winner, 1'b1, 1'b1, 1'b0);
    bus.UnitBusy = 1'($urandom_range(0, 1));
    bus.UnitEnd  = 1'($urandom_range(0, 1));

    for (int j = 1; j <= done_j; j++) begin
      tick();
      chk_out({tag, "_wait"}, 2'b00, winner, 1'b1, 1'b0, 1'b0);
      bus.UnitBusy = (j >= a) && (hung || (j < a + len));
      bus.UnitEnd  = (j == e);
      if (add_other && j == 2) bus.Req[~winner] = 1'b1;
      if (glitch && j == a + len) begin
        #2 bus.UnitEnd = 1'b1;
        #1 bus.UnitEnd = 1'b0;
      end
    end

    tick();
    if (to_exp) err_model = 1'b1;
    chk_out({tag, "_done"}, winner ? 2'b10 : 2'b01, winner, 1'b1, 1'b0, to_exp);
    bus.Req[winner] = 1'b0;
    bus.UnitBusy    = 1'b0;
    bus.UnitEnd     = 1'b0;
    last_owner      = winner;

    tick();
    chk_out({tag, "_idle"}, 2'b00, winner, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    int a;
    int len;
    int e;
    bit hung;

    Reset        = 1'b1;
    bus.Req      = 2'b00;
    bus.UnitBusy = 1'b0;
    bus.UnitEnd  = 1'b0;
    last_owner   = 1'b1;
    err_model    = 1'b0;
    sel_model    = 1'b0;
    tick();
    tick();
    chk_out("reset", 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    Reset = 1'b0;

    idle_quiet("idle_spurious", 4);

    // Contention held: strict alternation starting with ch0.
    bus.Req = 2'b11;
    run_txn("cont0", 1, 3, 0, 1'b0, 1'b0, 1'b0);
    bus.Req = 2'b11;
    run_txn("cont1", 2, 2, 0, 1'b0, 1'b0, 1'b0);
    bus.Req = 2'b11;
    run_txn("cont2", 1, 1, 0, 1'b0, 1'b0, 1'b0);
    bus.Req = 2'b00;
    idle_quiet("cont_drain", 1);

    bus.Req = 2'b01;
    run_txn("single", 1, 10, 0, 1'b0, 1'b0, 1'b0);

    bus.Req = 2'b01;
    run_txn("glitch", 1, 5, 0, 1'b0, 1'b1, 1'b0);

    bus.Req = 2'b01;
    run_txn("end_only", 1, 0, 3, 1'b0, 1'b0, 1'b0);

    bus.Req = 2'b10;
    run_txn("hung", 1, 0, 0, 1'b1, 1'b0, 1'b0);

    bus.Req = 2'b01;
    run_txn("after_hung", 2, 3, 0, 1'b0, 1'b0, 1'b0);

    bus.Req = 2'b10;
    run_txn("end_at_limit", 1, 0, TIMEOUT, 1'b0, 1'b0, 1'b0);

    // Reset in the middle of WAIT.
    bus.Req = 2'b01;
    tick();
    sel_model = 1'b0;
    chk_out("rst_mid_start", 2'b00, 1'b0, 1'b1, 1'b1, 1'b0);
    bus.UnitBusy = 1'b1;
    tick();
    tick();
    chk_out("rst_mid_wait", 2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
    Reset   = 1'b1;
    bus.Req = 2'b00;
    tick();
    last_owner = 1'b1;
    err_model  = 1'b0;
    sel_model  = 1'b0;
    chk_out("rst_mid_after", 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    Reset = 1'b0;
    idle_quiet("rst_mid_noack", 3);
    bus.Req = 2'b10;
    run_txn("after_rst", 1, 4, 0, 1'b0, 1'b0, 1'b0);

    for (int t = 0; t < 30; t++) begin
      if (bus.Req == 2'b00 && $urandom_range(0, 3) == 0)
        idle_quiet("rand_idle", $urandom_range(1, 3));
      bus.Req = bus.Req | 2'($urandom_range(1, 3));
      hung = ($urandom_range(0, 9) == 0);
      a    = $urandom_range(1, 3);
      len  = $urandom_range(0, 9);
      e    = (len == 0 || $urandom_range(0, 1) == 1) ? $urandom_range(1, 20) : 0;
      if (hung) e = 0;
      run_txn("rand", a, len, e, hung, len > 0 && $urandom_range(0, 1) == 1,
              $urandom_range(0, 1) == 1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/proc_share_arbiter.md
Name: proc_share_arbiter

Overview:
- Shares one Start/Busy/End processing unit (FFT/window stage) between the left (0) and right (1) channel requesters of the stereo spectrum path.
- Grants the unit round-robin, fires a single Start pulse and waits for completion.
- Returns a one-cycle Ack to the owning channel; a watchdog aborts a hung unit.
- Sits between the channel frame controllers and the shared unit's input/output muxes, which Sel drives.

Parameters:
- TIMEOUT, 1024: max cycles in WAIT before abort; legal 2..2^CW-1.
- CW, 11: width of the watchdog counter.

Ports:
- Clock  in  1  system clock, all logic on rising edge
- Reset  in  1  synchronous, active-high reset
- Req  in  2  per-channel level request; held until Ack, dropped the cycle after Ack
- Ack  out  2  one-cycle completion pulse to the owning channel
- Sel  out  1  current/last owner channel; drives unit data muxes
- Active  out  1  high from grant until Ack cycle inclusive
- UnitStart  out  1  one-cycle start pulse to shared unit
- UnitBusy  in  1  unit busy level
- UnitEnd  in  1  unit end pulse, may be shorter than one cycle
- Timeout  out  1  one-cycle pulse when the watchdog aborts
- ErrFlag  out  1  sticky; set on any timeout, cleared only by Reset

Behaviour:
- All outputs are registered.
- Reset (sync, active-high) values: state=IDLE, Ack=0, Sel=0, Active=0, UnitStart=0, Timeout=0, ErrFlag=0, Last=1 (so ch0 wins the first contention), busy_d=0, counter=0.
- Reset asserted mid-operation aborts immediately to reset values. No Ack is issued; the unit is not re-started.
- State machine, one transition per clock:
  - IDLE: sample Req. If none, stay. If one bit is set, grant it. If both are set, grant the channel != Last. Latch Sel, set Active=1, go START.
  - START: UnitStart=1 for exactly this cycle. Clear counter, busy_d=0. Go WAIT.
  - WAIT: each cycle busy_d<=UnitBusy and counter++.
    - done = UnitEnd | (busy_d & ~UnitBusy). The falling edge of Busy is accepted because an End narrower than one clock may never be sampled.
    - If done, go DONE.
    - Else if counter==TIMEOUT-1, pulse Timeout, set ErrFlag, go DONE.
    - done wins over timeout in the same cycle.
  - DONE: Ack[Sel]=1 for one cycle; the other Ack bit stays 0. Ack is also issued after a timeout, so the requester never deadlocks; the requester checks Timeout. Last<=Sel. Active=0 at the next edge. Go IDLE.
- Latency:
  - Req high at edge k (IDLE): UnitStart high in cycle k+1.
  - Completion sampled at edge m: Ack high in cycle m+1.
  - Back-to-back grants: minimum period = 3 + unit duration cycles; IDLE takes one cycle between grants.
- Req changes outside IDLE are ignored. Sel is stable from grant through the Ack cycle.
- UnitBusy/UnitEnd are ignored outside WAIT. A stray End in IDLE does nothing.
- UnitBusy high already in the first WAIT cycle with no prior low is fine; only the high→low transition counts.
- A unit that finishes without ever raising Busy must pulse UnitEnd ≥1 full cycle, or it times out.
- Counter saturates and never wraps.

Test Plan:
- Single request, unit model Busy=10 cycles then End: Req=01 at edge 0 → UnitStart cycle 1, Sel=0, Ack=01 one cycle ≈ cycle 13, Timeout=0.
- Contention after reset, Req=11 held: grants ch0 first (Ack=01), then ch1 (Ack=10), then ch0 again; strict alternation, no double Ack.
- Sub-cycle End (1 ns glitch between edges), Busy falls: completion detected via Busy falling edge; Ack issued exactly once, one cycle after the fall.
- Hung unit (Busy stuck high), TIMEOUT=16: Timeout pulses 16 cycles after entering WAIT, ErrFlag=1 and stays 1, Ack still issued. A following request runs normally with ErrFlag still 1.
- Reset asserted mid-WAIT for 1 cycle: all outputs 0 next cycle, no Ack. A later Req=10 is granted (Last=1 reset value overridden only by contention; a single request wins).
- Req=00 with spurious UnitEnd/UnitBusy toggling in IDLE: no state change, UnitStart/Ack/Timeout remain 0.
